// File: rtl/add_accum_pipe.sv
// Add/saturate/subtract/accumulate unit whose results are queued in a small FIFO.
// An accepted operation is written to the FIFO on the same edge, so results appear one cycle after acceptance.
module add_accum_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       acc_clr,
  output logic [WIDTH-1:0]           res,
  output logic                       flag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mem_res [DEPTH];
  logic             mem_flag [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] op_res;
  logic             op_flag;

  // Reset masks both handshakes so nothing is accepted or popped on a reset edge.
  assign out_valid = !rst && (cnt != '0);
  assign in_ready  = !rst && ((cnt < FULL_CNT) || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;
  assign res       = out_valid ? mem_res[rd_ptr] : '0;
  assign flag      = out_valid ? mem_flag[rd_ptr] : 1'b0;

  always_comb begin
    acc_base = acc_clr ? '0 : acc;
    add_sum  = {1'b0, a} + {1'b0, b};
    acc_sum  = {1'b0, acc_base} + {1'b0, a};
    op_res   = '0;
    op_flag  = 1'b0;
    case (mode)
      2'b00: begin
        op_res  = add_sum[WIDTH-1:0];
        op_flag = add_sum[WIDTH];
      end
      2'b01: begin
        op_res  = add_sum[WIDTH] ? '1 : add_sum[WIDTH-1:0];
        op_flag = add_sum[WIDTH];
      end
      2'b10: begin
        if (a >= b) op_res = a - b;
        else        op_flag = 1'b1;
      end
      default: begin
        op_res  = acc_sum[WIDTH-1:0];
        op_flag = acc_sum[WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && mode == 2'b11) acc <= acc_sum[WIDTH-1:0];
      else if (acc_clr)          acc <= '0;
    end
  end

  // Storage needs no reset; the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_ptr]  <= op_res;
      mem_flag[wr_ptr] <= op_flag;
    end
  end

endmodule

// File: tb/tb_add_accum_pipe.sv
// Self-checking bench for add_accum_pipe: a reference model feeds a scoreboard queue,
// plus a table of known operation results and hand-written FIFO/reset sequences.
module tb_add_accum_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int MAXV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic             acc_clr;
  logic [WIDTH-1:0] res;
  logic             flag;
  logic             out_valid;
  logic             out_ready;
  logic [$clog2(DEPTH):0] count;

  add_accum_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .acc_clr(acc_clr),
    .res(res), .flag(flag), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         a;
    int         b;
    bit         clr;
    int         exp_res;
    bit         exp_flag;
  } vec_t;

  typedef struct {
    int r;
    bit f;
  } exp_t;

  exp_t exp_q[$];
  int   model_acc = 0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, checks the handshake before the edge, updates the
  // reference model on the edge and compares the FIFO head afterwards.
  task automatic applyStimulus(input bit r, input bit iv, input logic [1:0] m,
                               input int av, input int bv, input bit clr, input bit orr);
    int   sz;
    int   s;
    int   accv;
    int   er;
    bit   ef;
    bit   exp_ready;
    bit   do_push;
    bit   do_pop;
    exp_t e;
    rst = r; in_valid = iv; mode = m; a = av[WIDTH-1:0]; b = bv[WIDTH-1:0];
    acc_clr = clr; out_ready = orr;
    #1;
    sz = exp_q.size();
    exp_ready = !r && (sz < DEPTH || orr);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    checkOutput("out_valid_pre", {31'b0, out_valid}, {31'b0, (!r && sz > 0)});
    do_push = iv && exp_ready;
    do_pop  = !r && sz > 0 && orr;
    accv = clr ? 0 : model_acc;
    er = 0; ef = 0;
    case (m)
      2'd0: begin s = av + bv; er = s % MAXV; ef = (s >= MAXV); end
      2'd1: begin s = av + bv; er = (s >= MAXV) ? MAXV - 1 : s; ef = (s >= MAXV); end
      2'd2: begin er = (av >= bv) ? av - bv : 0; ef = (av < bv); end
      default: begin s = accv + av; er = s % MAXV; ef = (s >= MAXV); end
    endcase
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      model_acc = 0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        e.r = er; e.f = ef;
        exp_q.push_back(e);
      end
      if (do_push && m == 2'd3) model_acc = er;
      else if (clr)             model_acc = 0;
    end
    #1;
    checkOutput("count", {28'b0, count}, exp_q.size());
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, (!r && exp_q.size() > 0)});
    if (!r && exp_q.size() > 0) begin
      checkOutput("res", {24'b0, res}, exp_q[0].r);
      checkOutput("flag", {31'b0, flag}, {31'b0, exp_q[0].f});
    end else begin
      checkOutput("res_empty", {24'b0, res}, 0);
      checkOutput("flag_empty", {31'b0, flag}, 0);
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, 200, 100, 1'b0,  44, 1'b1};
    vecs[1] = '{2'd1, 200, 100, 1'b0, 255, 1'b1};
    vecs[2] = '{2'd1,  10,  20, 1'b0,  30, 1'b0};
    vecs[3] = '{2'd2,   5,   9, 1'b0,   0, 1'b1};
    vecs[4] = '{2'd2,   9,   5, 1'b0,   4, 1'b0};
    vecs[5] = '{2'd3, 100,   0, 1'b0, 100, 1'b0};
    vecs[6] = '{2'd3, 100,  55, 1'b0, 200, 1'b0};
    vecs[7] = '{2'd3, 100,   0, 1'b0,  44, 1'b1};
    vecs[8] = '{2'd3,   7,   0, 1'b1,   7, 1'b0};

    applyStimulus(1, 1, 2'd0, 1, 1, 0, 1);
    applyStimulus(1, 1, 2'd0, 1, 1, 0, 1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].clr, 1);
      checkOutput($sformatf("vec%0d_res", i), {24'b0, res}, vecs[i].exp_res);
      checkOutput($sformatf("vec%0d_flag", i), {31'b0, flag}, {31'b0, vecs[i].exp_flag});
      checkOutput($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 1);
      if (i == 0) checkOutput("vec0_count", {28'b0, count}, 1);
    end

    // Fill to full with the consumer stalled, then stream through a full FIFO.
    applyStimulus(0, 0, 2'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 2'd0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 2'd0, 10 * i + 1, i, 0, 0);
    checkOutput("full_count", {28'b0, count}, 4);
    #1;
    checkOutput("full_in_ready", {31'b0, in_ready}, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 2'd1, 60 + i, 150 + 20 * i, 0, 1);
      checkOutput("stream_count", {28'b0, count}, 4);
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 2'd0, 0, 0, 0, 1);

    // Pending results and accumulator are discarded by reset.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2'd3, 50, 0, 0, 0);
    applyStimulus(1, 1, 2'd3, 9, 0, 1, 1);
    checkOutput("rst_count", {28'b0, count}, 0);
    applyStimulus(0, 1, 2'd3, 1, 0, 0, 0);
    checkOutput("post_rst_res", {24'b0, res}, 1);
    checkOutput("post_rst_flag", {31'b0, flag}, 0);
    applyStimulus(0, 0, 2'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 2'd0, 0, 0, 0, 1);

    // Standalone clear, then accumulate from zero.
    applyStimulus(0, 1, 2'd3, 30, 0, 0, 1);
    applyStimulus(0, 0, 2'd3, 5, 0, 1, 1);
    applyStimulus(0, 1, 2'd3, 8, 0, 0, 1);
    checkOutput("clr_res", {24'b0, res}, 8);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(($urandom_range(39) == 0), $urandom_range(1), 2'($urandom_range(3)),
                    $urandom_range(255), $urandom_range(255), ($urandom_range(7) == 0),
                    $urandom_range(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_accum_pipe.md
ADD_ACCUM_PIPE -- requirements
Module: add_accum_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width (legal range >= 2).
REQ-002 SHALL have parameter DEPTH, default 4, giving the result FIFO depth (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port a, input, WIDTH bits: operand A.
REQ-006 SHALL have port b, input, WIDTH bits: operand B.
REQ-007 SHALL have port mode, input, 2 bits: operation select, sampled with the operands.
REQ-008 SHALL have port in_valid, input, 1 bit: the operands and mode are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-010 SHALL have port acc_clr, input, 1 bit: synchronous clear of the accumulator.
REQ-011 SHALL have port res, output, WIDTH bits: the result at the FIFO head.
REQ-012 SHALL have port flag, output, 1 bit: carry/clamp/borrow of the head result.
REQ-013 SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer takes the head this cycle.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of entries in the FIFO.

Function
REQ-016 SHALL accept an operation on a rising edge where in_valid && in_ready; any other cycle SHALL leave the block state unchanged except for pops and acc_clr.
REQ-017 SHALL pop the FIFO head on a rising edge where out_valid && out_ready.
REQ-018 SHALL compute the result from a, b, mode and the accumulator at accept time, and write it into the FIFO on that same edge, giving 1-cycle latency.
- An accept on edge N into an empty FIFO SHALL give out_valid=1 and the new res after edge N.
REQ-019 mode 00, wrap add: res = (a+b) mod 2^WIDTH; flag = carry out.
REQ-020 mode 01, saturating add: res = min(a+b, 2^WIDTH-1); flag = 1 iff the result was clamped.
REQ-021 mode 10, saturating subtract: res = a-b if a>=b, else 0; flag = 1 iff a<b.
REQ-022 mode 11, accumulate: acc_next = (acc + a) mod 2^WIDTH; res = acc_next; flag = carry out; b is ignored.
- acc SHALL update only on an accepted mode-11 operation.
REQ-023 acc_clr=1 SHALL set acc to 0 on the edge.
- If acc_clr coincides with an accepted mode-11 operation, the operation SHALL use acc=0, so acc_next = a.
- acc_clr SHALL NOT affect FIFO contents.
REQ-024 in_ready SHALL be (count < DEPTH) || out_ready.
- When full, a simultaneous pop and push SHALL be allowed and count SHALL stay DEPTH.
REQ-025 Simultaneous push and pop at any fill level SHALL leave count unchanged and preserve FIFO order.
REQ-026 When the FIFO is empty: out_valid=0, res=0, flag=0; a pop request SHALL be ignored.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH with no loss or duplication of entries.
REQ-028 Results SHALL leave the FIFO strictly in acceptance order.

Reset
REQ-029 While rst=1 on an edge, the block SHALL clear the FIFO pointers, count and acc to 0.
- Reset SHALL discard any pending operation and any queued results.
REQ-030 While rst=1: in_ready=0 and out_valid=0.
- After reset: res=0, flag=0, count=0.
- From the first cycle with rst=0: in_ready=1.
REQ-031 Reset asserted mid-operation SHALL take priority over an accept, a pop and acc_clr on the same edge.

Verification (WIDTH=8, DEPTH=4)
REQ-032 mode00, a=200, b=100 -> next cycle res=44, flag=1, out_valid=1, count=1.
REQ-033 mode01, 200+100 -> res=255, flag=1; then mode01, 10+20 -> res=30, flag=0.
REQ-034 mode10, 5-9 -> res=0, flag=1; then mode10, 9-5 -> res=4, flag=0.
REQ-035 mode11, a=100 three times -> res=100,200,44 with flags 0,0,1; then acc_clr=1 with mode11, a=7 -> res=7.
REQ-036 out_ready=0 with 5 pushes attempted -> 4 accepted, in_ready=0, count=4; then out_ready=1 and in_valid=1 together -> one push and one pop per cycle, count=4, results in order.
REQ-037 3 results queued, then rst=1 for 1 cycle with in_valid=1 -> out_valid=0, count=0, acc=0; next mode11, a=1 -> res=1, flag=0.
